ifu_icache_ctrl: RTL and testbench

Miss/fill controller for the IFU instruction cache: fully associative, 16 entries, 128-bit lines, 28-bit tag, 4-bit byte offset.
- Owns the tag/valid array and the replacement pointer.
- Sequences hit lookup, line fetch from memory, and data-array fill.
- Sits between the fetch stage (request side) and the memory read port. The external data array is written by this block and read by fetch using rsp_idx_o/rsp_offset_o.

---
 rtl/ifu_icache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ifu_icache_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_icache_ctrl.sv
// Miss/fill controller for the IFU instruction cache.
// It owns the tag/valid array and the round-robin victim pointer, and it
// sequences the hit lookup, the memory line fetch and the data-array fill.
module ifu_icache_ctrl #(
    parameter int unsigned NUM_TAGS     = 16,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned LINE_WIDTH   = 128,
    localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - OFFSET_WIDTH,
    localparam int unsigned P_BITS      = $clog2(NUM_TAGS)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    req_valid_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    output logic                    req_ready_o,
    input  logic                    flush_i,
    output logic                    rsp_valid_o,
    output logic [P_BITS-1:0]       rsp_idx_o,
    output logic [OFFSET_WIDTH-1:0] rsp_offset_o,
    output logic                    mem_rd_req_valid_o,
    output logic [ADDR_WIDTH-1:0]   mem_rd_req_addr_o,
    input  logic                    mem_rd_req_ready_i,
    input  logic                    mem_rd_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0]   mem_rd_rsp_data_i,
    output logic                    data_wr_en_o,
    output logic [P_BITS-1:0]       data_wr_idx_o,
    output logic [LINE_WIDTH-1:0]   data_wr_line_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        FILL      = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [P_BITS-1:0]       victim_q, victim_d;
    logic                    from_ptr_q, from_ptr_d;
    logic [P_BITS-1:0]       ptr_q, ptr_d;
    logic [NUM_TAGS-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0]    tag_q [NUM_TAGS];
    logic                    tag_we;

    logic                    hit;
    logic [P_BITS-1:0]       hit_idx;
    logic                    inv_found;
    logic [P_BITS-1:0]       inv_idx;
    logic [TAG_WIDTH-1:0]    req_tag;

    logic                    rsp_valid_d;
    logic [P_BITS-1:0]       rsp_idx_d;
    logic [OFFSET_WIDTH-1:0] rsp_offset_d;
    logic                    mem_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic                    wr_en_d;
    logic [P_BITS-1:0]       wr_idx_d;
    logic [LINE_WIDTH-1:0]   wr_line_d;

    assign req_tag = addr_q[ADDR_WIDTH-1:OFFSET_WIDTH];

    // Ready is the only combinational output; reset forces it low as well.
    assign req_ready_o = (state_q == IDLE) && !flush_i && !Rst;

    // Next-state, tag-array bookkeeping and next values of registered outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        victim_d   = victim_q;
        from_ptr_d = from_ptr_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        tag_we     = 1'b0;
        hit        = 1'b0;
        hit_idx    = '0;
        inv_found  = 1'b0;
        inv_idx    = '0;

        // Lowest matching valid entry and lowest invalid entry.
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (!hit && valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = P_BITS'(i);
            end
            if (!inv_found && !valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = P_BITS'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    valid_d = '0;
                    ptr_d   = '0;
                end else if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    victim_d = hit_idx;
                    state_d  = RESP;
                end else begin
                    victim_d   = inv_found ? inv_idx : ptr_q;
                    from_ptr_d = !inv_found;
                    state_d    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_rd_req_ready_i) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rd_rsp_valid_i) state_d = FILL;
            end
            FILL: begin
                valid_d[victim_q] = 1'b1;
                tag_we            = 1'b1;
                if (from_ptr_q) ptr_d = ptr_q + P_BITS'(1);
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp_valid_d  = (state_d == RESP);
        rsp_idx_d    = (state_d == RESP) ? victim_d : rsp_idx_o;
        rsp_offset_d = (state_d == RESP) ? addr_q[OFFSET_WIDTH-1:0] : rsp_offset_o;
        mem_valid_d  = (state_d == MISS_REQ);
        mem_addr_d   = (state_d == MISS_REQ) ?
                       {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} :
                       mem_rd_req_addr_o;
        wr_en_d      = (state_d == FILL);
        wr_idx_d     = (state_d == FILL) ? victim_q : data_wr_idx_o;
        wr_line_d    = (state_q == MISS_WAIT && mem_rd_rsp_valid_i) ?
                       mem_rd_rsp_data_i : data_wr_line_o;
    end

    // Control state, valid bits, victim pointer and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q            <= IDLE;
            addr_q             <= '0;
            victim_q           <= '0;
            from_ptr_q         <= 1'b0;
            ptr_q              <= '0;
            valid_q            <= '0;
            rsp_valid_o        <= 1'b0;
            rsp_idx_o          <= '0;
            rsp_offset_o       <= '0;
            mem_rd_req_valid_o <= 1'b0;
            mem_rd_req_addr_o  <= '0;
            data_wr_en_o       <= 1'b0;
            data_wr_idx_o      <= '0;
            data_wr_line_o     <= '0;
        end else begin
            state_q            <= state_d;
            addr_q             <= addr_d;
            victim_q           <= victim_d;
            from_ptr_q         <= from_ptr_d;
            ptr_q              <= ptr_d;
            valid_q            <= valid_d;
            rsp_valid_o        <= rsp_valid_d;
            rsp_idx_o          <= rsp_idx_d;
            rsp_offset_o       <= rsp_offset_d;
            mem_rd_req_valid_o <= mem_valid_d;
            mem_rd_req_addr_o  <= mem_addr_d;
            data_wr_en_o       <= wr_en_d;
            data_wr_idx_o      <= wr_idx_d;
            data_wr_line_o     <= wr_line_d;
        end
    end

    // Tag array; an entry's tag is written when its line is filled.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) tag_q[i] <= '0;
        end else if (tag_we) begin
            tag_q[victim_q] <= req_tag;
        end
    end

endmodule

// File: tb/tb_ifu_icache_ctrl.sv
// Bench for ifu_icache_ctrl: a line-level cache model predicts hit/miss,
// entry index and fill contents; a per-cycle monitor checks DUT outputs
// against the model's expectation queues.
module tb_ifu_icache_ctrl;

    logic         Clk;
    logic         Rst;
    logic         req_valid_i;
    logic [31:0]  req_addr_i;
    logic         req_ready_o;
    logic         flush_i;
    logic         rsp_valid_o;
    logic [3:0]   rsp_idx_o;
    logic [3:0]   rsp_offset_o;
    logic         mem_rd_req_valid_o;
    logic [31:0]  mem_rd_req_addr_o;
    logic         mem_rd_req_ready_i;
    logic         mem_rd_rsp_valid_i;
    logic [127:0] mem_rd_rsp_data_i;
    logic         data_wr_en_o;
    logic [3:0]   data_wr_idx_o;
    logic [127:0] data_wr_line_o;

    ifu_icache_ctrl dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .req_valid_i        (req_valid_i),
        .req_addr_i         (req_addr_i),
        .req_ready_o        (req_ready_o),
        .flush_i            (flush_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_idx_o          (rsp_idx_o),
        .rsp_offset_o       (rsp_offset_o),
        .mem_rd_req_valid_o (mem_rd_req_valid_o),
        .mem_rd_req_addr_o  (mem_rd_req_addr_o),
        .mem_rd_req_ready_i (mem_rd_req_ready_i),
        .mem_rd_rsp_valid_i (mem_rd_rsp_valid_i),
        .mem_rd_rsp_data_i  (mem_rd_rsp_data_i),
        .data_wr_en_o       (data_wr_en_o),
        .data_wr_idx_o      (data_wr_idx_o),
        .data_wr_line_o     (data_wr_line_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] idx;
        logic [3:0] off;
    } rsp_t;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] line;
    } fill_t;

    int checks = 0;
    int errors = 0;

    // Cache model: which line address lives in which entry.
    bit          m_val [16];
    logic [27:0] m_tag [16];
    int          m_ptr;

    rsp_t        exp_rsp_q [$];
    fill_t       exp_fill_q [$];
    logic [31:0] exp_mem_addr;

    logic [3:0]  last_rsp_idx;
    logic [3:0]  last_rsp_off;
    logic [3:0]  last_fill_idx;
    logic [31:0] last_mem_addr;
    int          fill_count = 0;
    int          base_fills;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
        m_ptr = 0;
    endtask

    // Hit if the line is resident; otherwise lowest free entry, else round-robin.
    task automatic predict(input logic [31:0] a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && m_val[i] && m_tag[i] == a[31:4]) begin
                hit = 1'b1;
                idx = i;
            end
        end
        if (!hit) begin
            idx = -1;
            for (int i = 0; i < 16; i++) if (idx < 0 && !m_val[i]) idx = i;
            if (idx < 0) begin
                idx   = m_ptr;
                m_ptr = (m_ptr + 1) % 16;
            end
            m_val[idx] = 1'b1;
            m_tag[idx] = a[31:4];
        end
    endtask

    // Per-cycle monitor against the model's expectation queues.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (rsp_valid_o) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp idx=%0h off=%0h", rsp_idx_o, rsp_offset_o);
                end else begin
                    rsp_t r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_idx", 128'(rsp_idx_o), 128'(r.idx));
                    chk("rsp_offset", 128'(rsp_offset_o), 128'(r.off));
                end
                last_rsp_idx = rsp_idx_o;
                last_rsp_off = rsp_offset_o;
            end
            if (data_wr_en_o) begin
                fill_count++;
                if (exp_fill_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fill idx=%0h", data_wr_idx_o);
                end else begin
                    fill_t f;
                    f = exp_fill_q.pop_front();
                    chk("fill_idx", 128'(data_wr_idx_o), 128'(f.idx));
                    chk("fill_line", data_wr_line_o, f.line);
                end
                last_fill_idx = data_wr_idx_o;
            end
            if (mem_rd_req_valid_o) begin
                chk("mem_addr", 128'(mem_rd_req_addr_o), 128'(exp_mem_addr));
                last_mem_addr = mem_rd_req_addr_o;
            end
        end
    end

    // Issue one request and drive memory for it when the model predicts a miss.
    task automatic do_req(input logic [31:0] a, input int bp, input bit spur,
                          input logic [127:0] line);
        bit          hit;
        int          idx;
        int          n;
        bit          fill_prev;
        logic [31:0] cap;
        rsp_t        r;
        fill_t       f;
        predict(a, hit, idx);
        r.idx = 4'(idx);
        r.off = a[3:0];
        exp_rsp_q.push_back(r);
        if (!hit) begin
            f.idx  = 4'(idx);
            f.line = line;
            exp_fill_q.push_back(f);
            exp_mem_addr = {a[31:4], 4'h0};
        end
        @(negedge Clk);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        #1 chk("req_ready_idle", 128'(req_ready_o), 128'(1));
        @(posedge Clk);
        @(negedge Clk);
        req_valid_i = 1'b0;
        if (hit) begin
            chk("hit_c1_rsp", 128'(rsp_valid_o), 128'(0));
            chk("hit_c1_mem", 128'(mem_rd_req_valid_o), 128'(0));
            @(negedge Clk);
            chk("hit_c2_rsp", 128'(rsp_valid_o), 128'(1));
            chk("hit_c2_mem", 128'(mem_rd_req_valid_o), 128'(0));
            @(negedge Clk);
            chk("hit_c3_ready", 128'(req_ready_o), 128'(1));
        end else begin
            n = 0;
            while (!mem_rd_req_valid_o && n < 8) begin
                @(negedge Clk);
                n++;
            end
            chk("miss_mem_req_seen", 128'(mem_rd_req_valid_o), 128'(1));
            cap = mem_rd_req_addr_o;
            for (int k = 0; k < bp; k++) begin
                chk("bp_valid_stable", 128'(mem_rd_req_valid_o), 128'(1));
                chk("bp_addr_stable", 128'(mem_rd_req_addr_o), 128'(cap));
                if (spur && k == 1) begin
                    mem_rd_rsp_valid_i = 1'b1;
                    mem_rd_rsp_data_i  = ~line;
                end
                @(negedge Clk);
                mem_rd_rsp_valid_i = 1'b0;
            end
            mem_rd_req_ready_i = 1'b1;
            @(negedge Clk);
            mem_rd_req_ready_i = 1'b0;
            mem_rd_rsp_valid_i = 1'b1;
            mem_rd_rsp_data_i  = line;
            @(negedge Clk);
            mem_rd_rsp_valid_i = 1'b0;
            mem_rd_rsp_data_i  = '0;
            n = 0;
            fill_prev = 1'b0;
            while (!rsp_valid_o && n < 8) begin
                fill_prev = data_wr_en_o;
                @(negedge Clk);
                n++;
            end
            chk("miss_rsp_seen", 128'(rsp_valid_o), 128'(1));
            chk("fill_before_rsp", 128'(fill_prev), 128'(1));
            @(negedge Clk);
            chk("miss_ready_after", 128'(req_ready_o), 128'(1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        flush_i = 1'b0;
        mem_rd_req_ready_i = 1'b0;
        mem_rd_rsp_valid_i = 1'b0;
        mem_rd_rsp_data_i = '0;
        model_clear();
        #2 Rst = 1'b1;
        repeat (2) @(negedge Clk);
        req_valid_i = 1'b1;
        #1;
        chk("reset_outputs",
            128'({req_ready_o, rsp_valid_o, rsp_idx_o, rsp_offset_o, mem_rd_req_valid_o,
                  mem_rd_req_addr_o, data_wr_en_o, data_wr_idx_o}), 128'(0));
        chk("reset_wr_line", data_wr_line_o, 128'(0));
        req_valid_i = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;

        // Cold miss
        do_req(32'h0000_1234, 0, 1'b0, {16{8'hA5}});
        chk("cold_mem_addr", 128'(last_mem_addr), 128'(32'h0000_1230));
        chk("cold_fill_idx", 128'(last_fill_idx), 128'(0));
        chk("cold_rsp_idx", 128'(last_rsp_idx), 128'(0));
        chk("cold_rsp_off", 128'(last_rsp_off), 128'(4));

        // Hit on the same line
        base_fills = fill_count;
        do_req(32'h0000_123C, 0, 1'b0, '0);
        chk("hit_rsp_idx", 128'(last_rsp_idx), 128'(0));
        chk("hit_rsp_off", 128'(last_rsp_off), 128'(4'hC));
        chk("hit_no_fill", 128'(fill_count), 128'(base_fills));

        // Fill the remaining entries in order
        for (int i = 1; i < 16; i++) begin
            do_req(32'h0002_0000 + 32'(i << 4), 0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
            chk("fill_order", 128'(last_fill_idx), 128'(i));
        end

        // Round-robin replacement, with backpressure and a spurious response
        do_req(32'h0003_0000, 0, 1'b0, {4{32'hDEAD_BEEF}});
        chk("rr17_idx", 128'(last_fill_idx), 128'(0));
        do_req(32'h0003_0018, 5, 1'b1, {4{32'h1234_5678}});
        chk("rr18_idx", 128'(last_fill_idx), 128'(1));
        chk("rr18_off", 128'(last_rsp_off), 128'(8));
        do_req(32'h0003_0004, 0, 1'b0, '0);
        chk("rr17_hit_idx", 128'(last_rsp_idx), 128'(0));
        base_fills = fill_count;
        do_req(32'h0000_1230, 0, 1'b0, {8{16'hC3C3}});
        chk("evicted_misses", 128'(fill_count), 128'(base_fills + 1));
        chk("evicted_fill_idx", 128'(last_fill_idx), 128'(2));

        // Flush beats a simultaneous request
        @(negedge Clk);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_1230;
        #1 chk("flush_ready_low", 128'(req_ready_o), 128'(0));
        @(negedge Clk);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        model_clear();
        repeat (3) @(negedge Clk);
        chk("flush_no_rsp", 128'(exp_rsp_q.size()), 128'(0));
        do_req(32'h0000_1230, 0, 1'b0, {4{32'h0F0F_0F0F}});
        chk("flush_refill_idx", 128'(last_fill_idx), 128'(0));

        // Reset in MISS_WAIT, then a late memory response
        exp_mem_addr = 32'h0005_0000;
        @(negedge Clk);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0005_0000;
        @(posedge Clk);
        @(negedge Clk);
        req_valid_i = 1'b0;
        for (int n = 0; n < 8 && !mem_rd_req_valid_o; n++) @(negedge Clk);
        chk("rstmiss_mem_req", 128'(mem_rd_req_valid_o), 128'(1));
        mem_rd_req_ready_i = 1'b1;
        @(negedge Clk);
        mem_rd_req_ready_i = 1'b0;
        Rst = 1'b1;
        #1;
        chk("rstmiss_outputs",
            128'({req_ready_o, rsp_valid_o, rsp_idx_o, rsp_offset_o, mem_rd_req_valid_o,
                  mem_rd_req_addr_o, data_wr_en_o, data_wr_idx_o}), 128'(0));
        chk("rstmiss_wr_line", data_wr_line_o, 128'(0));
        model_clear();
        exp_rsp_q.delete();
        exp_fill_q.delete();
        @(negedge Clk);
        Rst = 1'b0;
        base_fills = fill_count;
        mem_rd_rsp_valid_i = 1'b1;
        mem_rd_rsp_data_i  = {4{32'hBAD0_BAD0}};
        @(negedge Clk);
        mem_rd_rsp_valid_i = 1'b0;
        repeat (4) @(negedge Clk);
        chk("late_rsp_no_fill", 128'(fill_count), 128'(base_fills));
        do_req(32'h0000_1234, 0, 1'b0, {4{32'h7777_1111}});
        chk("post_reset_misses", 128'(fill_count), 128'(base_fills + 1));
        chk("post_reset_idx", 128'(last_fill_idx), 128'(0));

        repeat (3) @(negedge Clk);
        chk("rsp_queue_drained", 128'(exp_rsp_q.size()), 128'(0));
        chk("fill_queue_drained", 128'(exp_fill_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
